// File: rtl/rgb_pwm_ctrl_if.sv
// Configuration bus for rgb_pwm_ctrl: a single-cycle write strobe carrying
// the target channel and its mode, duty and step rate.
interface rgb_pwm_ctrl_if #(
  parameter int NUM_CH    = 3,
  parameter int PWM_BITS  = 8,
  parameter int RATE_BITS = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [1:0]           cfg_mode;
  logic [PWM_BITS-1:0]  cfg_duty;
  logic [RATE_BITS-1:0] cfg_rate;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_rate);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_rate);
endinterface

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel PWM controller for the RGBxPWM inputs of SB_RGBA_DRV:
// shared prescaler and PWM counter, per-channel off/static/blink/breathe.
module rgb_pwm_ctrl #(
  parameter int NUM_CH    = 3,
  parameter int PWM_BITS  = 8,
  parameter int CLK_DIV   = 48,
  parameter int RATE_BITS = 8
) (
  input  logic              int_osc,
  input  logic              rst,
  input  logic              en,
  rgb_pwm_ctrl_if.slave     cfg,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0]   pwm_out_q;
  logic                period_tick_q;
  logic                tick;
  logic                period_end;
  logic [PWM_BITS-1:0] eff_duty [NUM_CH];

  // Timebase only advances while enabled, so en=0 freezes everything downstream.
  always_comb begin
    tick       = en && (presc_q == PRESC_MAX);
    period_end = tick && (&pwm_cnt_q);
    presc_d    = presc_q;
    pwm_cnt_d  = pwm_cnt_q;
    if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge int_osc) begin
    if (rst) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      period_tick_q <= 1'b0;
      pwm_out_q     <= '0;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      period_tick_q <= period_end;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out_q[i] <= en && (eff_duty[i] > pwm_cnt_q);
      end
    end
  end

  assign pwm_out     = pwm_out_q;
  assign period_tick = period_tick_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    mode_e                mode_q, mode_d;
    dir_e                 dir_q, dir_d;
    logic [PWM_BITS-1:0]  duty_q, duty_d;
    logic [PWM_BITS-1:0]  level_q, level_d;
    logic [RATE_BITS-1:0] rate_q, rate_d;
    logic [RATE_BITS-1:0] step_q, step_d;
    logic                 phase_q, phase_d;
    logic                 cfg_hit;
    logic                 step_fire;

    // Out-of-range channel indices never match any gi, so such writes drop.
    assign cfg_hit   = cfg.cfg_we && (cfg.cfg_ch == CH_W'(gi));
    assign step_fire = period_end && (step_q == rate_q);

    always_comb begin
      mode_d  = mode_q;
      duty_d  = duty_q;
      rate_d  = rate_q;
      step_d  = step_q;
      phase_d = phase_q;
      level_d = level_q;
      dir_d   = dir_q;
      if (cfg_hit) begin
        mode_d  = mode_e'(cfg.cfg_mode);
        duty_d  = cfg.cfg_duty;
        rate_d  = cfg.cfg_rate;
        step_d  = '0;
        phase_d = 1'b0;
        level_d = '0;
        dir_d   = DIR_UP;
      end else if (period_end) begin
        step_d = step_fire ? '0 : step_q + 1'b1;
        if (step_fire && mode_q == MODE_BLINK) begin
          phase_d = ~phase_q;
        end
        // Reversal steps hold the level, giving a one-step dwell at each end.
        if (step_fire && mode_q == MODE_BREATHE) begin
          if (dir_q == DIR_UP) begin
            if (level_q >= duty_q) dir_d = DIR_DOWN;
            else                   level_d = level_q + 1'b1;
          end else begin
            if (level_q == '0) dir_d = DIR_UP;
            else               level_d = level_q - 1'b1;
          end
        end
      end
    end

    always_ff @(posedge int_osc) begin
      if (rst) begin
        mode_q  <= MODE_OFF;
        duty_q  <= '0;
        rate_q  <= '0;
        step_q  <= '0;
        phase_q <= 1'b0;
        level_q <= '0;
        dir_q   <= DIR_UP;
      end else begin
        mode_q  <= mode_d;
        duty_q  <= duty_d;
        rate_q  <= rate_d;
        step_q  <= step_d;
        phase_q <= phase_d;
        level_q <= level_d;
        dir_q   <= dir_d;
      end
    end

    assign eff_duty[gi] = (mode_q == MODE_STATIC)             ? duty_q  :
                          (mode_q == MODE_BLINK && phase_q)   ? duty_q  :
                          (mode_q == MODE_BREATHE)            ? level_q : '0;
  end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
Parametrised multi-channel PWM controller that drives the RGBxPWM inputs of the SB_RGBA_DRV LED driver, replacing fixed counter-bit decoding. Each channel has a programmable mode (off / static / blink / breathe), an 8-bit-class duty and a step rate. A shared prescaler and PWM counter time all channels. The block sits between the SB_HFOSC clock and the RGB driver primitive.

Parameters:
NUM_CH, 3, number of PWM channels (>=1)
PWM_BITS, 8, PWM counter and duty width; period = 2**PWM_BITS ticks
CLK_DIV, 48, clocks per PWM tick (>=1; 48 gives a 1 MHz tick from 48 MHz)
RATE_BITS, 8, width of per-channel blink/breathe step-rate field

Ports:
int_osc  in  1  clock, single clock domain
rst  in  1  synchronous active-high reset
en  in  1  global enable; low freezes the timebase and forces outputs low
cfg_we  in  1  configuration write strobe, single cycle
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index
cfg_mode  in  2  0=OFF, 1=STATIC, 2=BLINK, 3=BREATHE
cfg_duty  in  PWM_BITS  duty (STATIC/BLINK) or peak level (BREATHE)
cfg_rate  in  RATE_BITS  PWM periods per step = cfg_rate+1
pwm_out  out  NUM_CH  active-high PWM, one bit per channel, to RGBxPWM
period_tick  out  1  one-cycle pulse per completed PWM period

Behaviour:
- Reset (rst=1 at an int_osc edge): presc_cnt=0, pwm_cnt=0, pwm_out=0, period_tick=0. Every channel: mode=OFF, duty=0, rate=0, step_cnt=0, blink_phase=0, level=0, dir=UP. Reset overrides en and cfg_we.
- Prescaler: with en=1, presc_cnt counts 0..CLK_DIV-1. tick is asserted when presc_cnt==CLK_DIV-1, and presc_cnt returns to 0 on the next edge. CLK_DIV=1 gives a tick every cycle.
- PWM counter: increments by 1 on each tick and wraps from 2**PWM_BITS-1 to 0. period_end = tick && pwm_cnt==max.
- period_tick: registered. High for exactly one cycle, on the cycle in which pwm_cnt first reads 0 after a wrap.
- en=0: presc_cnt, pwm_cnt, step counters and breathe state hold their values. pwm_out is 0 on the next edge. Config writes are still accepted. When en returns high, counting resumes from the held values.
- Effective duty per channel:
  - OFF: 0.
  - STATIC: duty.
  - BLINK: blink_phase ? duty : 0.
  - BREATHE: level.
- Output: pwm_out[i] <= en && (eff_duty[i] > pwm_cnt), registered, giving one cycle of latency from pwm_cnt. Duty 0 means never high. Duty max means high for 2**PWM_BITS-1 of every 2**PWM_BITS ticks; 100% is not reachable.
- Step event per channel: on period_end, if step_cnt==rate then step_cnt<=0 and a step fires; otherwise step_cnt<=step_cnt+1. Channels in OFF or STATIC also count, but their output ignores the steps.
- BLINK step: blink_phase toggles. The output is off for the first rate+1 periods after configuration, then on for rate+1 periods, and so on.
- BREATHE step:
  - If dir=UP: when level>=duty, dir<=DOWN and level holds; otherwise level+1.
  - If dir=DOWN: when level==0, dir<=UP and level holds; otherwise level-1.
  - The result is a triangle wave with a one-step dwell at the peak and at 0. With duty=0 the level stays 0.
- Config write (cfg_we=1, cfg_ch<NUM_CH): on that edge, load mode, duty and rate, and clear step_cnt, blink_phase, level and dir(=UP) for that channel only. The new values affect pwm_out from the following edge. Other channels are undisturbed, and the timebase is not reset.
- cfg_ch>=NUM_CH: write ignored, no state change.
- Write coincident with a step event on the same channel: the write wins and the step is discarded.
- Counter wrap is modular at PWM_BITS. step_cnt is RATE_BITS wide and never exceeds rate.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cfg_we=1 and en=1 -> pwm_out=0, period_tick=0 throughout, and every channel reads back OFF (pwm_out stays 0 after release with no writes).
- STATIC, PWM_BITS=4, CLK_DIV=1, ch0 duty=4 -> pwm_out[0] high exactly 4 of every 16 cycles, aligned one cycle after pwm_cnt=0..3; period_tick every 16 cycles. ch1 duty=0 -> never high. ch2 duty=15 -> high 15 of 16.
- BLINK, ch1 duty=8, rate=1 (PWM_BITS=4, CLK_DIV=1) -> 2 periods fully low, then 2 periods with 8 high cycles each, repeating.
- BREATHE, ch2 duty=3, rate=0 -> per-period high counts 0,1,2,3,3,2,1,0,0,1,2...
- Boundaries:
  - Write with cfg_ch=3 (NUM_CH=3) -> no change on any channel.
  - Rewrite ch2 mid-breathe -> level restarts at 0.
  - en=0 for 5 cycles mid-period -> pwm_out=0 within 1 cycle, pwm_cnt frozen, counting resumes from the same value.
- CLK_DIV=3 -> pwm_cnt advances every 3 cycles; a duty=1 pulse is 3 cycles wide; the period is 48 cycles for PWM_BITS=4.
